// File: rtl/gate_accumulator.sv
// Framed bitwise reduction: folds every beat of a frame through one selectable
// gate (AND/OR/XOR and inversions) and holds one result word until it is taken.
module gate_accumulator #(
   parameter int WIDTH       = 16,
   parameter int COUNT_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_data,
   input  logic                   in_last,
   input  logic [2:0]             op,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_data,
   output logic [COUNT_WIDTH-1:0] out_count,
   output logic                   out_sat,
   output logic                   out_err
);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

   state_t                 state_q, state_d;
   logic [WIDTH-1:0]       acc_q, acc_d;
   logic [2:0]             op_q, op_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic                   sat_q, sat_d;
   logic                   beat;

   // Inverting ops accumulate with their base gate; inversion is applied only on output.
   function automatic logic [WIDTH-1:0] base_gate(input logic [2:0] o,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
      case (o)
         3'b001, 3'b100: base_gate = a | b;
         3'b010, 3'b101: base_gate = a ^ b;
         default:        base_gate = a & b;
      endcase
   endfunction

   function automatic logic is_inverting(input logic [2:0] o);
      is_inverting = (o == 3'b011) || (o == 3'b100) || (o == 3'b101);
   endfunction

   assign in_ready  = !reset && (state_q != DONE);
   assign out_valid = (state_q == DONE);
   assign beat      = in_valid && in_ready;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      op_d    = op_q;
      count_d = count_q;
      sat_d   = sat_q;
      case (state_q)
         IDLE: begin
            if (beat) begin
               acc_d   = in_data;
               op_d    = op;
               count_d = COUNT_WIDTH'(1);
               sat_d   = 1'b0;
               state_d = in_last ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            if (beat) begin
               acc_d   = base_gate(op_q, acc_q, in_data);
               count_d = (count_q == COUNT_MAX) ? COUNT_MAX : count_q + COUNT_WIDTH'(1);
               sat_d   = sat_q || (count_d == COUNT_MAX);
               state_d = in_last ? DONE : ACCUM;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Result fields read as zero whenever no result is being presented.
   always_comb begin
      out_data  = '0;
      out_count = '0;
      out_sat   = 1'b0;
      out_err   = 1'b0;
      if (state_q == DONE) begin
         out_data  = is_inverting(op_q) ? ~acc_q : acc_q;
         out_count = count_q;
         out_sat   = sat_q;
         out_err   = (op_q[2:1] == 2'b11);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         acc_q   <= '0;
         op_q    <= '0;
         count_q <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         op_q    <= op_d;
         count_q <= count_d;
         sat_q   <= sat_d;
      end
   end

endmodule

// File: tb/tb_gate_accumulator.sv
// Bench for gate_accumulator: directed frames with literal expectations plus a
// per-cycle comparison against a frame-level reduction model.
module tb_gate_accumulator;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = '0;
   logic        in_last = 1'b0;
   logic [2:0]  op = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_data;
   logic [7:0]  out_count;
   logic        out_sat;
   logic        out_err;

   int vectors = 0;
   int miscompares = 0;
   bit armed = 1'b0;

   gate_accumulator #(.WIDTH(16), .COUNT_WIDTH(8)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_last(in_last), .op(op),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_count(out_count), .out_sat(out_sat), .out_err(out_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: remember the words of the current frame, reduce them when the frame ends.
   bit          m_done = 1'b0;
   bit          m_infr = 1'b0;
   logic [2:0]  m_op;
   logic [15:0] q[$];
   logic [15:0] e_data;
   int          e_n;
   bit          e_err;

   always @(negedge clk) begin
      if (armed) begin
         chk("in_ready", 32'(in_ready), 32'(!reset && !m_done));
         chk("out_valid", 32'(out_valid), 32'(m_done));
         if (m_done) begin
            chk("out_data", 32'(out_data), 32'(e_data));
            chk("out_count", 32'(out_count), (e_n > 255) ? 32'd255 : 32'(e_n));
            chk("out_sat", 32'(out_sat), 32'(e_n >= 255));
            chk("out_err", 32'(out_err), 32'(e_err));
         end
         if (reset) begin
            m_done = 1'b0;
            m_infr = 1'b0;
            q.delete();
         end else if (m_done) begin
            if (out_ready) m_done = 1'b0;
         end else if (in_valid) begin
            if (!m_infr) begin
               q.delete();
               m_op = op;
            end
            q.push_back(in_data);
            m_infr = 1'b1;
            if (in_last) begin
               e_data = q[0];
               for (int i = 1; i < q.size(); i++) begin
                  case (m_op)
                     3'd1, 3'd4: e_data = e_data | q[i];
                     3'd2, 3'd5: e_data = e_data ^ q[i];
                     default:    e_data = e_data & q[i];
                  endcase
               end
               if (m_op inside {3'd3, 3'd4, 3'd5}) e_data = ~e_data;
               e_n    = q.size();
               e_err  = (m_op >= 3'd6);
               m_done = 1'b1;
               m_infr = 1'b0;
            end
         end
      end
   end

   logic [15:0] fw[0:7];

   task automatic send_frame(input logic [2:0] o, input logic [2:0] omid, input int n);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = fw[i];
         in_last  = (i == n - 1);
         op       = (i == 0) ? o : omid;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic expect_result(input string nm, input logic [15:0] d, input int c,
                                input bit s, input bit e);
      chk({nm, ".valid"}, 32'(out_valid), 32'd1);
      chk({nm, ".data"}, 32'(out_data), 32'(d));
      chk({nm, ".count"}, 32'(out_count), 32'(c));
      chk({nm, ".sat"}, 32'(out_sat), 32'(s));
      chk({nm, ".err"}, 32'(out_err), 32'(e));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({nm, ".released"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] held;
      repeat (3) @(posedge clk);
      #1;
      armed = 1'b1;
      chk("rst.in_ready", 32'(in_ready), 32'd0);
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.out_data", 32'(out_data), 32'd0);
      chk("rst.out_count", 32'(out_count), 32'd0);
      chk("rst.out_sat_err", {out_sat, out_err}, 32'd0);
      in_valid = 1'b1;
      in_data  = 16'hABCD;
      in_last  = 1'b1;
      @(posedge clk); #1;
      chk("rst.beat_dropped", 32'(out_valid), 32'd0);
      in_valid = 1'b0;
      in_last  = 1'b0;
      reset = 1'b0;
      #1;
      chk("idle.in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;

      // AND truth table over two-beat frames
      for (int k = 0; k < 4; k++) begin
         fw[0] = k[1] ? 16'hFFFF : 16'h0000;
         fw[1] = k[0] ? 16'hFFFF : 16'h0000;
         send_frame(3'd0, 3'd0, 2);
         expect_result("and_tt", (k == 3) ? 16'hFFFF : 16'h0000, 2, 1'b0, 1'b0);
      end

      fw[0] = 16'hF0F0; fw[1] = 16'hFF00; fw[2] = 16'h0FF0;
      send_frame(3'd1, 3'd1, 3); expect_result("or3",   16'hFFF0, 3, 1'b0, 1'b0);
      send_frame(3'd2, 3'd2, 3); expect_result("xor3",  16'h0000, 3, 1'b0, 1'b0);
      send_frame(3'd3, 3'd3, 3); expect_result("nand3", 16'hFFFF, 3, 1'b0, 1'b0);
      send_frame(3'd4, 3'd4, 3); expect_result("nor3",  16'h000F, 3, 1'b0, 1'b0);
      send_frame(3'd5, 3'd5, 3); expect_result("xnor3", 16'hFFFF, 3, 1'b0, 1'b0);

      fw[0] = 16'h1234;
      send_frame(3'd3, 3'd3, 1);
      expect_result("nand1", 16'hEDCB, 1, 1'b0, 1'b0);

      // Backpressure with a new beat waiting
      fw[0] = 16'hA5A5; fw[1] = 16'h0F0F;
      send_frame(3'd2, 3'd2, 2);
      held = out_data;
      chk("bp.data", 32'(held), 32'h0000AAAA);
      in_valid = 1'b1; in_data = 16'h5555; in_last = 1'b1; op = 3'd1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp.in_ready", 32'(in_ready), 32'd0);
         chk("bp.stable", 32'(out_data), 32'(held));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp.idle_ready", 32'(in_ready), 32'd1);
      chk("bp.idle_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
      expect_result("bp.next", 16'h5555, 1, 1'b0, 1'b0);

      // Saturating beat count
      for (int i = 0; i < 300; i++) begin
         in_valid = 1'b1;
         in_data  = 16'hFFFF;
         in_last  = (i == 299);
         op       = 3'd2;
         @(posedge clk); #1;
      end
      in_valid = 1'b0; in_last = 1'b0;
      expect_result("sat300", 16'h0000, 255, 1'b1, 1'b0);

      // Reset mid-frame discards the partial result
      fw[0] = 16'h1111; fw[1] = 16'h2222;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_data = fw[i]; in_last = 1'b0; op = 3'd1;
         @(posedge clk); #1;
      end
      reset = 1'b1; in_data = 16'hFFFF; in_last = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("midrst.no_valid", 32'(out_valid), 32'd0);
         @(posedge clk); #1;
      end
      fw[0] = 16'h0F00; fw[1] = 16'h00F0;
      send_frame(3'd1, 3'd1, 2);
      expect_result("after_rst", 16'h0FF0, 2, 1'b0, 1'b0);

      // Unsupported op behaves as AND and flags err; mid-frame op ignored
      fw[0] = 16'h00FF; fw[1] = 16'h0F0F;
      send_frame(3'd7, 3'd1, 2);
      expect_result("op7", 16'h000F, 2, 1'b0, 1'b1);
      fw[0] = 16'hC3C3; fw[1] = 16'hFF00; fw[2] = 16'h0FF0;
      send_frame(3'd0, 3'd5, 3);
      expect_result("op_mid", 16'h0300, 3, 1'b0, 1'b0);
      fw[0] = 16'h8001;
      send_frame(3'd6, 3'd6, 1);
      expect_result("op6", 16'h8001, 1, 1'b0, 1'b1);

      repeat (2) @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/gate_accumulator.md
Name: gate_accumulator

Overview:
- Parametrised, sequential successor to the two-input combinational gate.
- Folds a framed stream of WIDTH-bit words through one selectable bitwise gate (AND/OR/XOR and their inversions) and presents a single result word per frame.
- Serves as the multi-operand bitwise reduction stage for the Hack datapath: mask building, parity words and flag collapse.
- valid/ready handshake on both sides so it can sit between registered stages.

Parameters:
- WIDTH, 16, data word width in bits (Hack word).
- COUNT_WIDTH, 8, width of the beat counter and out_count.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- in_valid  input  1  in_data/in_last/op are valid this cycle.
- in_ready  output  1  block accepts an input beat this cycle.
- in_data  input  WIDTH  operand word.
- in_last  input  1  marks final beat of a frame.
- op  input  3  gate select; sampled on the first beat of a frame only.
- out_valid  output  1  out_data/out_count/out_sat/out_err hold a result.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  reduction result.
- out_count  output  COUNT_WIDTH  beats in the frame (saturating).
- out_sat  output  1  beat count saturated.
- out_err  output  1  op latched for the frame was unsupported.

Behaviour:
- Clock and reset:
  - One clock domain (clk).
  - reset is synchronous and active-high, sampled on the rising edge of clk.
- Beat and result handshakes:
  - An input beat is accepted when in_valid and in_ready are both 1 on a rising edge.
  - A result is consumed when out_valid and out_ready are both 1.
- op encoding:
  - 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR.
  - 110 and 111 are unsupported: treated as AND and out_err=1 for that frame.
- States: IDLE, ACCUM, DONE. in_ready = 1 in IDLE and ACCUM, 0 in DONE and while reset is high. out_valid = 1 only in DONE.
- IDLE, on an accepted beat:
  - acc<=in_data; op_r<=op; count<=1; sat<=0.
  - Next state: DONE if in_last, else ACCUM.
- ACCUM, on an accepted beat:
  - acc<=acc base(op_r) in_data, where the base gate is AND for AND/NAND/unsupported, OR for OR/NOR, XOR for XOR/XNOR.
  - count<=count+1, saturating at 2^COUNT_WIDTH-1; sat<=1 once saturation is reached.
  - op input is ignored mid-frame.
  - Next state: DONE if in_last, else stay in ACCUM.
  - No beat in a cycle: state and acc hold.
- DONE:
  - out_data = ~acc for NAND/NOR/XNOR, acc otherwise.
  - out_count=count; out_sat=sat; out_err=(op_r[2:1]==2'b11).
  - Outputs stay stable until out_ready; on handshake, next state is IDLE.
- Single-beat frame: out_data = in_data, or ~in_data for inverting ops (e.g. NAND of one word = its complement).
- Latency:
  - out_valid rises the cycle after the last beat is accepted.
  - The earliest next-frame beat is accepted the cycle after the result handshake.
- Backpressure: out_ready low holds DONE indefinitely; no input is accepted meanwhile.
- Reset:
  - Values: state=IDLE; acc, count, op_r, sat = 0; out_valid=0, out_data=0, out_count=0, out_sat=0, out_err=0; in_ready=0.
  - Reset mid-frame or in DONE discards the partial or pending result; nothing is emitted.
- Simultaneous reset and in_valid: reset wins; the beat is not accepted.
- Counter wrap: count never wraps; it saturates and out_sat flags it. acc keeps folding correctly past saturation.

Test Plan (WIDTH=16, COUNT_WIDTH=8):
- Truth table over a 2-beat frame, inputs 0x0000/0xFFFF in all four combinations, op=AND -> out_data 0x0000, 0x0000, 0x0000, 0xFFFF; out_count=2, out_err=0.
- 3-beat frame 0xF0F0, 0xFF00, 0x0FF0: OR -> 0xFFF0; XOR -> 0x0000; NAND -> 0xFFFF; NOR -> 0x000F; XNOR -> 0xFFFF.
- Single beat 0x1234 with in_last, op=NAND -> out_data 0xEDCB, out_count=1, out_valid one cycle after acceptance.
- Hold out_ready=0 for 5 cycles with a result pending, drive in_valid=1 -> in_ready=0 throughout, outputs stable; then out_ready=1 -> IDLE next cycle.
- 300-beat frame of 0xFFFF, op=XOR -> out_count=255, out_sat=1, out_data=0x0000. Assert reset after beat 2 of another frame -> no out_valid; next frame is correct.
- op=111 frame 0x00FF, 0x0F0F -> out_data 0x000F, out_err=1. Change op mid-frame -> ignored.
